// File: rtl/iotdf_pkg.sv
// Shared IoT data filter definitions: widths, CRC-8 polynomial, serializer FSM
// encodings and a CRC-8 byte-update helper.
package iotdf_pkg;

  localparam int unsigned IOTDF_RES_W     = 128;
  localparam int unsigned IOTDF_BYTE_W    = 8;
  localparam logic [7:0]  IOTDF_CRC8_POLY = 8'h07;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t StIdle = 2'd0;
  localparam ser_state_t StSend = 2'd1;
  localparam ser_state_t StCrc  = 2'd2;

  // MSB-first CRC-8 over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ IOTDF_CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/iotdf_res_fifo.sv
// DEPTH x 128-bit result FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle, otherwise the word is dropped and flagged.
module iotdf_res_fifo
  import iotdf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_req,
  input  logic [IOTDF_RES_W-1:0] push_data,
  input  logic                   pop,
  output logic [IOTDF_RES_W-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IOTDF_RES_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   full, pop_ok, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push_req && (!full || pop_ok);
  assign dropped = push_req && full && !pop_ok;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/iotdf_result_serializer.sv
// Buffers 128-bit filter results and streams them MSB byte first over a
// valid/ready byte port. Define IOTDF_SER_CRC_EN to append a CRC-8 byte per frame.
module iotdf_result_serializer
  import iotdf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_valid,
  input  logic [IOTDF_RES_W-1:0]  res_data,
  output logic                    ser_valid,
  output logic [IOTDF_BYTE_W-1:0] ser_data,
  input  logic                    ser_ready,
  output logic                    ser_last,
  output logic                    ovf,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [IOTDF_RES_W-1:0]  head;
  logic                    fifo_empty, fifo_dropped;
  logic                    pop, hs, more;
  logic [IOTDF_BYTE_W-1:0] head_byte;
  ser_state_t              state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic                    ovf_q;
`ifdef IOTDF_SER_CRC_EN
  logic [7:0]              crc_q, crc_d;
`endif

  iotdf_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (res_valid),
    .push_data (res_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign hs  = ser_valid && ser_ready;
  assign ovf = ovf_q;
  // Entries left after this pop: a concurrent push always lands when popping.
  assign more = (fifo_count > CW'(1)) || res_valid;

  // Byte idx starts at bit 127 - 8*idx = {~idx, 3'b111}.
  assign head_byte = head[{~idx_q, 3'b111} -: IOTDF_BYTE_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
`ifdef IOTDF_SER_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StSend;
      end
      StSend: begin
        if (hs) begin
          idx_d = idx_q + 4'd1;
`ifdef IOTDF_SER_CRC_EN
          crc_d = crc8_update((idx_q == 4'd0) ? 8'h00 : crc_q, head_byte);
          if (idx_q == 4'hF) state_d = StCrc;
`else
          if (idx_q == 4'hF) begin
            pop     = 1'b1;
            state_d = more ? StSend : StIdle;
          end
`endif
        end
      end
`ifdef IOTDF_SER_CRC_EN
      StCrc: begin
        if (hs) begin
          pop     = 1'b1;
          crc_d   = 8'h00;
          state_d = more ? StSend : StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ser_valid = 1'b0;
    ser_data  = '0;
    ser_last  = 1'b0;
    case (state_q)
      StSend: begin
        ser_valid = 1'b1;
        ser_data  = head_byte;
`ifndef IOTDF_SER_CRC_EN
        ser_last  = (idx_q == 4'hF);
`endif
      end
`ifdef IOTDF_SER_CRC_EN
      StCrc: begin
        ser_valid = 1'b1;
        ser_data  = crc_q;
        ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      ovf_q   <= 1'b0;
`ifdef IOTDF_SER_CRC_EN
      crc_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_q | fifo_dropped;
`ifdef IOTDF_SER_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_iotdf_result_serializer.sv
// Scoreboard bench for iotdf_result_serializer; honours IOTDF_SER_CRC_EN when defined.
module tb_iotdf_result_serializer;

  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         res_valid = 1'b0;
  logic [127:0] res_data = '0;
  logic         ser_valid;
  logic [7:0]   ser_data;
  logic         ser_ready = 1'b0;
  logic         ser_last;
  logic         ovf;
  logic [2:0]   fifo_count;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  iotdf_result_serializer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_ready  (ser_ready),
    .ser_last   (ser_last),
    .ovf        (ovf),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bit-serial CRC-8 (poly 0x07) over the whole word, MSB first.
  function automatic logic [7:0] model_crc(input logic [127:0] w);
    logic [7:0] c = 8'h00;
    for (int b = 127; b >= 0; b--) begin
      logic fb;
      fb = c[7] ^ w[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic expect_word(input logic [127:0] w);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.data = w[127 - 8*i -: 8];
`ifdef IOTDF_SER_CRC_EN
      e.last = 1'b0;
`else
      e.last = (i == 15);
`endif
      exp_q.push_back(e);
    end
`ifdef IOTDF_SER_CRC_EN
    e.data = model_crc(w);
    e.last = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [127:0] w, input bit accepted);
    res_valid = 1'b1;
    res_data  = w;
    if (accepted) expect_word(w);
    tick();
    res_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && !ser_valid && fifo_count == 0) done = 1'b1;
      else begin
        tick();
        if (toggle) ser_ready = ~ser_ready;
      end
    end
    ser_ready = 1'b1;
    check("drain_queue_empty", 128'(exp_q.size()), 0);
    check("drain_fifo_count", fifo_count, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_ser_last", ser_last, 0);
    check("rst_ovf", ovf, 0);
    check("rst_fifo_count", fifo_count, 0);
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: compares at the falling edge, pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (ser_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", ser_valid, 0);
        end else begin
          check("byte", ser_data, exp_q[0].data);
          check("last", ser_last, exp_q[0].last);
          if (ser_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_out", {ser_last, ser_data}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w0, w[6];
    bit found;

    w0 = 128'h0F0E0D0C0B0A09080706050403020100;
    for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom, $urandom, $urandom};

    do_reset();

    // Single word, latency and byte order.
    ser_ready = 1'b1;
    push_word(w0, 1'b1);
    check("lat_count_n1", fifo_count, 1);
    check("lat_valid_n1", ser_valid, 0);
    tick();
    check("lat_valid_n2", ser_valid, 1);
    check("lat_first_byte", ser_data, 8'h0F);
    drain(1'b0);

    // Same word under toggling ready.
    push_word(w0, 1'b1);
    drain(1'b1);

    // Overflow: five pulses into a stalled four-deep FIFO.
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(w[i], i < 4);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", ovf, 1);
    ser_ready = 1'b1;
    drain(1'b0);
    check("ovf_sticky", ovf, 1);

    do_reset();

    // Push on the final-byte handshake with a full FIFO.
    ser_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b1);
    check("full_count", fifo_count, 4);
    ser_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (ser_valid && ser_last) found = 1'b1;
      else tick();
    end
    check("final_byte_seen", found, 1);
    push_word(w[5], 1'b1);
    check("simul_count", fifo_count, 4);
    check("simul_ovf", ovf, 0);
    drain(1'b0);

    // Reset in the middle of a frame.
    ser_ready = 1'b0;
    push_word(w[0], 1'b1);
    push_word(w[1], 1'b1);
    ser_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_idx7_byte", ser_data, w[0][71:64]);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", ser_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    tick();
    rst = 1'b0;
    tick();
    push_word(w[2], 1'b1);
    tick();
    check("post_rst_first", ser_data, w[2][127:120]);
    drain(1'b0);

`ifdef IOTDF_SER_CRC_EN
    push_word(128'h80, 1'b1);
    push_word(128'h0, 1'b1);
    drain(1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
